// File: rtl/aer_sched_pkg.sv
// Shared types and constants for the AER map scheduler.
// Optional ACK watchdog is enabled by defining AER_SCHED_TIMEOUT_EN.
package aer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    localparam logic [1:0] NEUR    = 2'b00;
    localparam logic [1:0] CTRL_A  = 2'b01;
    localparam logic [1:0] CTRL_B  = 2'b10;
    localparam logic [1:0] INVALID = 2'b11;

    localparam int unsigned EVT_CNT_W = 16;

endpackage

// File: rtl/aer_sched_fifo.sv
// Synchronous FIFO with occupancy output; DEPTH must be a power of two.
module aer_sched_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 22
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/aer_map_scheduler.sv
// Round-robin merge of N_SRC event producers into one REQ/ACK AER port via a shared FIFO.
// Define AER_SCHED_TIMEOUT_EN to build the ACK watchdog and sticky TIMEOUT_ERR.
module aer_map_scheduler
    import aer_sched_pkg::*;
#(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned AER_WIDTH   = 12,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DRAIN_CYC   = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_SRC-1:0]                 SRC_VALID,
    input  logic [N_SRC*AER_WIDTH-1:0]       SRC_EVENT,
    input  logic [N_SRC*(AER_WIDTH-2)-1:0]   SRC_IDX,
    output logic [N_SRC-1:0]                 SRC_READY,
    output logic                             MAP_AERIN_REQ,
    output logic [AER_WIDTH-1:0]             MAP_AERIN_EVENT,
    output logic [AER_WIDTH-3:0]             MAP_AERIN_IDX,
    input  logic                             MAP_AERIN_ACK,
    output logic                             BUSY,
    output logic [$clog2(FIFO_DEPTH):0]      FIFO_LEVEL,
    output logic [EVT_CNT_W-1:0]             EVT_CNT,
    output logic                             TIMEOUT_ERR
);

    localparam int unsigned IDX_W = AER_WIDTH - 2;
    localparam int unsigned ENT_W = AER_WIDTH + IDX_W;
    localparam int unsigned PTR_W = $clog2(N_SRC);
    localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W-1:0]     cand;
    logic [N_SRC-1:0]     grant;
    logic                 found;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENT_W-1:0]     fifo_wdata;
    logic [ENT_W-1:0]     fifo_rdata;

    sched_state_e         state_q, state_d;
    logic                 req_q, req_d;
    logic [AER_WIDTH-1:0] event_q, event_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [EVT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 first_q, first_d;
    logic [DRN_W-1:0]     drain_q, drain_d;

    // Search starts one past the last winner so every source gets a turn.
    always_comb begin
        grant   = '0;
        gnt_idx = rr_ptr_q;
        cand    = rr_ptr_q;
        found   = 1'b0;
        for (int k = 1; k <= int'(N_SRC); k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % int'(N_SRC));
            if (!found && SRC_VALID[cand]) begin
                grant[cand] = 1'b1;
                gnt_idx     = cand;
                found       = 1'b1;
            end
        end
    end

    assign SRC_READY  = rst_n ? (grant & {N_SRC{~fifo_full}}) : '0;
    assign push       = |SRC_READY;
    assign fifo_wdata = {SRC_EVENT[int'(gnt_idx)*AER_WIDTH +: AER_WIDTH],
                         SRC_IDX[int'(gnt_idx)*IDX_W +: IDX_W]};

    aer_sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (FIFO_LEVEL)
    );

`ifdef AER_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 :
                                    (($clog2(TIMEOUT_CYC + 1) > 16) ? 16 :
                                     $clog2(TIMEOUT_CYC + 1));
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    assign TIMEOUT_ERR = err_q;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        event_d = event_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        first_d = 1'b0;
        drain_d = drain_q;
        pop     = 1'b0;
`ifdef AER_SCHED_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop              = 1'b1;
                    {event_d, idx_d} = fifo_rdata;
                    req_d            = 1'b1;
                    first_d          = 1'b1;
                    state_d          = SEND;
`ifdef AER_SCHED_TIMEOUT_EN
                    tmo_d            = '0;
`endif
                end
            end
            SEND: begin
`ifdef AER_SCHED_TIMEOUT_EN
                tmo_d = tmo_q + 1'b1;
`endif
                // ACK seen in the first SEND cycle may be stale from the previous event.
                if (MAP_AERIN_ACK && !first_q) begin
                    req_d   = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    drain_d = '0;
                    state_d = DRAIN;
                end
`ifdef AER_SCHED_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    drain_d = '0;
                    state_d = DRAIN;
                end
`endif
            end
            DRAIN: begin
                if (drain_q == DRN_W'(DRAIN_CYC - 1)) state_d = IDLE;
                else                                 drain_d = drain_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= PTR_W'(N_SRC - 1);
            state_q  <= IDLE;
            req_q    <= 1'b0;
            event_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            drain_q  <= '0;
`ifdef AER_SCHED_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            if (push) rr_ptr_q <= gnt_idx;
            state_q  <= state_d;
            req_q    <= req_d;
            event_q  <= event_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            drain_q  <= drain_d;
`ifdef AER_SCHED_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    assign MAP_AERIN_REQ   = req_q;
    assign MAP_AERIN_EVENT = event_q;
    assign MAP_AERIN_IDX   = idx_q;
    assign EVT_CNT         = cnt_q;
    assign BUSY            = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_aer_map_scheduler.sv
// Directed self-checking bench for aer_map_scheduler; a behavioural mapper answers REQ with ACK.
// Build with AER_SCHED_TIMEOUT_EN defined to exercise the watchdog instead of the full-FIFO case.
module tb_aer_map_scheduler;
    import aer_sched_pkg::*;

    localparam int unsigned N_SRC = 4;
    localparam int unsigned AW    = 12;
    localparam int unsigned IW    = 10;
`ifdef AER_SCHED_TIMEOUT_EN
    localparam int unsigned TMO = 10;
`else
    localparam int unsigned TMO = 255;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [N_SRC-1:0]      SRC_VALID;
    logic [N_SRC*AW-1:0]   SRC_EVENT;
    logic [N_SRC*IW-1:0]   SRC_IDX;
    logic [N_SRC-1:0]      SRC_READY;
    logic                  MAP_AERIN_REQ;
    logic [AW-1:0]         MAP_AERIN_EVENT;
    logic [IW-1:0]         MAP_AERIN_IDX;
    logic                  MAP_AERIN_ACK;
    logic                  BUSY;
    logic [3:0]            FIFO_LEVEL;
    logic [15:0]           EVT_CNT;
    logic                  TIMEOUT_ERR;

    int checks;
    int errors;
    int ack_delay;   // 0: never ACK, 255: ACK held high, else ACK after that many REQ-high cycles
    int hi_cnt;
    logic [AW+IW-1:0] got_q[$];

    aer_map_scheduler #(
        .N_SRC       (N_SRC),
        .AER_WIDTH   (AW),
        .FIFO_DEPTH  (8),
        .DRAIN_CYC   (1),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .SRC_VALID       (SRC_VALID),
        .SRC_EVENT       (SRC_EVENT),
        .SRC_IDX         (SRC_IDX),
        .SRC_READY       (SRC_READY),
        .MAP_AERIN_REQ   (MAP_AERIN_REQ),
        .MAP_AERIN_EVENT (MAP_AERIN_EVENT),
        .MAP_AERIN_IDX   (MAP_AERIN_IDX),
        .MAP_AERIN_ACK   (MAP_AERIN_ACK),
        .BUSY            (BUSY),
        .FIFO_LEVEL      (FIFO_LEVEL),
        .EVT_CNT         (EVT_CNT),
        .TIMEOUT_ERR     (TIMEOUT_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mapper model: logs each event on REQ rise, ACKs per ack_delay.
    initial begin
        MAP_AERIN_ACK = 1'b0;
        hi_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (MAP_AERIN_REQ) begin
                hi_cnt++;
                if (hi_cnt == 1) got_q.push_back({MAP_AERIN_EVENT, MAP_AERIN_IDX});
                MAP_AERIN_ACK = (ack_delay == 255) || (ack_delay != 0 && hi_cnt >= ack_delay);
            end else begin
                hi_cnt = 0;
                MAP_AERIN_ACK = (ack_delay == 255);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [AW-1:0] ev, input logic [IW-1:0] ix);
        SRC_EVENT[s*AW +: AW] = ev;
        SRC_IDX[s*IW +: IW]   = ix;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        SRC_VALID = '0;
        ack_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((BUSY || MAP_AERIN_REQ) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, want idle", n);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        SRC_VALID = 4'hF;
        SRC_EVENT = '0;
        SRC_IDX   = '0;
        ack_delay = 0;
        #12;
        checks++;
        if (SRC_READY !== 4'b0000) begin
            errors++; $display("FAIL reset_ready_in_reset: got %b want 0000", SRC_READY);
        end
        do_reset();
        #1;
        checks++;
        if (MAP_AERIN_REQ !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", MAP_AERIN_REQ); end
        checks++;
        if (EVT_CNT !== 16'd0) begin errors++; $display("FAIL reset_evt_cnt: got %0d want 0", EVT_CNT); end
        checks++;
        if (FIFO_LEVEL !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", FIFO_LEVEL); end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++;
        if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", TIMEOUT_ERR); end
        checks++;
        if (MAP_AERIN_EVENT !== 12'h000) begin errors++; $display("FAIL reset_event: got %h want 000", MAP_AERIN_EVENT); end
    endtask

    task automatic test_single_event();
        int hi;
        do_reset();
        ack_delay = 3;
        set_src(2, 12'h0A5, 10'h025);
        SRC_VALID = 4'b0100;
        #1;
        checks++;
        if (SRC_READY !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", SRC_READY); end
        step();
        SRC_VALID = '0;
        #1;
        checks++;
        if (SRC_READY !== 4'b0000) begin errors++; $display("FAIL single_ready_drop: got %b want 0000", SRC_READY); end
        checks++;
        if (FIFO_LEVEL !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", FIFO_LEVEL); end
        checks++;
        if (MAP_AERIN_REQ !== 1'b0) begin errors++; $display("FAIL single_req_early: got %b want 0", MAP_AERIN_REQ); end
        step();
        checks++;
        if (MAP_AERIN_REQ !== 1'b1) begin errors++; $display("FAIL single_req_rise: got %b want 1", MAP_AERIN_REQ); end
        checks++;
        if (MAP_AERIN_EVENT !== 12'h0A5) begin errors++; $display("FAIL single_event: got %h want 0a5", MAP_AERIN_EVENT); end
        checks++;
        if (MAP_AERIN_IDX !== 10'h025) begin errors++; $display("FAIL single_idx: got %h want 025", MAP_AERIN_IDX); end
        checks++;
        if (FIFO_LEVEL !== 4'd0) begin errors++; $display("FAIL single_level_pop: got %0d want 0", FIFO_LEVEL); end
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!MAP_AERIN_REQ) break;
            hi++;
        end
        checks++;
        if (hi != 3) begin errors++; $display("FAIL single_req_len: got %0d want 3", hi); end
        checks++;
        if (EVT_CNT !== 16'd1) begin errors++; $display("FAIL single_evt_cnt: got %0d want 1", EVT_CNT); end
        wait_idle(20);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL single_issued: got %0d want 1", got_q.size()); end
    endtask

    task automatic test_ack_first_cycle();
        int hi;
        do_reset();
        ack_delay = 255;
        set_src(0, 12'h155, 10'h2AA);
        SRC_VALID = 4'b0001;
        step();
        SRC_VALID = '0;
        step();
        checks++;
        if (MAP_AERIN_REQ !== 1'b1) begin errors++; $display("FAIL ackhold_req_rise: got %b want 1", MAP_AERIN_REQ); end
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!MAP_AERIN_REQ) break;
            hi++;
        end
        checks++;
        if (hi != 2) begin errors++; $display("FAIL ackhold_req_len: got %0d want 2", hi); end
        checks++;
        if (EVT_CNT !== 16'd1) begin errors++; $display("FAIL ackhold_evt_cnt: got %0d want 1", EVT_CNT); end
        wait_idle(20);
    endtask

    task automatic test_round_robin();
        int acc[N_SRC];
        int pushes;
        int exp_src;
        int g;
        logic [AW+IW-1:0] exp_w;
        do_reset();
        ack_delay = 2;
        for (int s = 0; s < int'(N_SRC); s++) acc[s] = 0;
        pushes  = 0;
        exp_src = 0;
        for (int cyc = 0; cyc < 300 && pushes < 12; cyc++) begin
            for (int s = 0; s < int'(N_SRC); s++)
                set_src(s, {NEUR, 2'(s), 8'(acc[s])}, 10'(s * 16 + acc[s]));
            SRC_VALID = 4'hF;
            #1;
            if (SRC_READY != 4'b0000) begin
                g = 0;
                for (int s = 0; s < int'(N_SRC); s++) if (SRC_READY[s]) g = s;
                checks++;
                if (SRC_READY !== 4'(1 << exp_src)) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: got %b want %b", pushes, SRC_READY, 4'(1 << exp_src));
                end
                acc[g]++;
                pushes++;
                exp_src = (exp_src + 1) % int'(N_SRC);
            end
            step();
        end
        SRC_VALID = '0;
        checks++;
        if (pushes != 12) begin errors++; $display("FAIL rr_push_count: got %0d want 12", pushes); end
        for (int s = 0; s < int'(N_SRC); s++) begin
            checks++;
            if (acc[s] != 3) begin errors++; $display("FAIL rr_src%0d_count: got %0d want 3", s, acc[s]); end
        end
        wait_idle(400);
        checks++;
        if (got_q.size() != 12) begin errors++; $display("FAIL rr_issued: got %0d want 12", got_q.size()); end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            exp_w = {NEUR, 2'(i % 4), 8'(i / 4), 10'((i % 4) * 16 + i / 4)};
            checks++;
            if (got_q[i] !== exp_w) begin errors++; $display("FAIL rr_order[%0d]: got %h want %h", i, got_q[i], exp_w); end
        end
    endtask

`ifndef AER_SCHED_TIMEOUT_EN
    task automatic test_fifo_full();
        int pushes;
        logic [AW+IW-1:0] exp_w;
        do_reset();
        ack_delay = 0;
        pushes = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            set_src(0, 12'(12'h080 + pushes), 10'(10'h100 + pushes));
            SRC_VALID = 4'b0001;
            #1;
            if (SRC_READY[0]) pushes++;
            step();
        end
        #1;
        checks++;
        if (pushes != 9) begin errors++; $display("FAIL full_push_count: got %0d want 9", pushes); end
        checks++;
        if (FIFO_LEVEL !== 4'd8) begin errors++; $display("FAIL full_level: got %0d want 8", FIFO_LEVEL); end
        checks++;
        if (SRC_READY !== 4'b0000) begin errors++; $display("FAIL full_ready: got %b want 0000", SRC_READY); end
        checks++;
        if (MAP_AERIN_REQ !== 1'b1) begin errors++; $display("FAIL full_req: got %b want 1", MAP_AERIN_REQ); end
        checks++;
        if (MAP_AERIN_EVENT !== 12'h080) begin errors++; $display("FAIL full_inflight: got %h want 080", MAP_AERIN_EVENT); end
        SRC_VALID = '0;
        ack_delay = 2;
        wait_idle(200);
        checks++;
        if (got_q.size() != 9) begin errors++; $display("FAIL full_issued: got %0d want 9", got_q.size()); end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            exp_w = {12'(12'h080 + i), 10'(10'h100 + i)};
            checks++;
            if (got_q[i] !== exp_w) begin errors++; $display("FAIL full_order[%0d]: got %h want %h", i, got_q[i], exp_w); end
        end
        checks++;
        if (EVT_CNT !== 16'd9) begin errors++; $display("FAIL full_evt_cnt: got %0d want 9", EVT_CNT); end
    endtask
`endif

    task automatic test_ctrl_order();
        logic [AW-1:0] ev [4];
        logic [IW-1:0] ix [4];
        int span;
        ev[0] = 12'h012; ix[0] = 10'h101;
        ev[1] = 12'h034; ix[1] = 10'h202;
        ev[2] = 12'h456; ix[2] = 10'h303;   // type 01 control
        ev[3] = 12'h0AB; ix[3] = 10'h0F0;
        do_reset();
        ack_delay = 2;
        for (int i = 0; i < 4; i++) begin
            set_src(3, ev[i], ix[i]);
            SRC_VALID = 4'b1000;
            #1;
            checks++;
            if (SRC_READY !== 4'b1000) begin errors++; $display("FAIL ctrl_ready[%0d]: got %b want 1000", i, SRC_READY); end
            step();
        end
        SRC_VALID = '0;
        span = 0;
        while ((BUSY || MAP_AERIN_REQ) && span < 100) begin
            span++;
            step();
        end
        // Four events at one per 4 cycles, first REQ one cycle after the first push.
        checks++;
        if (span != 13) begin errors++; $display("FAIL ctrl_throughput: got %0d busy cycles want 13", span); end
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL ctrl_issued: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {ev[i], ix[i]}) begin
                errors++; $display("FAIL ctrl_order[%0d]: got %h want %h", i, got_q[i], {ev[i], ix[i]});
            end
        end
        checks++;
        if (EVT_CNT !== 16'd4) begin errors++; $display("FAIL ctrl_evt_cnt: got %0d want 4", EVT_CNT); end
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        ack_delay = 0;
        for (int i = 0; i < 4; i++) begin
            set_src(1, 12'(12'h300 + i), 10'(i));
            SRC_VALID = 4'b0010;
            step();
        end
        SRC_VALID = '0;
        checks++;
        if (FIFO_LEVEL !== 4'd3) begin errors++; $display("FAIL midrst_pre_level: got %0d want 3", FIFO_LEVEL); end
        checks++;
        if (MAP_AERIN_REQ !== 1'b1) begin errors++; $display("FAIL midrst_pre_req: got %b want 1", MAP_AERIN_REQ); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (MAP_AERIN_REQ !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b want 0", MAP_AERIN_REQ); end
        checks++;
        if (FIFO_LEVEL !== 4'd0) begin errors++; $display("FAIL midrst_level: got %0d want 0", FIFO_LEVEL); end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", BUSY); end
        #4;
        rst_n = 1'b1;
        got_q.delete();
        step();
        for (int s = 0; s < int'(N_SRC); s++) set_src(s, 12'(12'h0E0 + s), 10'(10'h3E0 + s));
        SRC_VALID = 4'hF;
        #1;
        checks++;
        if (SRC_READY !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant: got %b want 0001", SRC_READY); end
        step();
        SRC_VALID = '0;
        ack_delay = 2;
        wait_idle(40);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {12'h0E0, 10'h3E0}) begin
            errors++;
            $display("FAIL midrst_issued: got %0d events first %h want 1 event %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, {12'h0E0, 10'h3E0});
        end
    endtask

`ifdef AER_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int hi;
        int n;
        do_reset();
        ack_delay = 0;
        set_src(0, 12'h0C1, 10'h011);
        SRC_VALID = 4'b0001;
        step();
        set_src(0, 12'h0C2, 10'h022);
        step();
        SRC_VALID = '0;
        checks++;
        if (MAP_AERIN_REQ !== 1'b1) begin errors++; $display("FAIL tmo_req_rise: got %b want 1", MAP_AERIN_REQ); end
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!MAP_AERIN_REQ) break;
            hi++;
        end
        checks++;
        if (hi != 10) begin errors++; $display("FAIL tmo_req_len: got %0d want 10", hi); end
        checks++;
        if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", TIMEOUT_ERR); end
        checks++;
        if (EVT_CNT !== 16'd0) begin errors++; $display("FAIL tmo_evt_cnt: got %0d want 0", EVT_CNT); end
        n = 0;
        while (!MAP_AERIN_REQ && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (MAP_AERIN_REQ !== 1'b1 || MAP_AERIN_EVENT !== 12'h0C2) begin
            errors++; $display("FAIL tmo_next_event: got req %b event %h want req 1 event 0c2",
                                MAP_AERIN_REQ, MAP_AERIN_EVENT);
        end
        wait_idle(40);
        checks++;
        if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b want 1", TIMEOUT_ERR); end
        checks++;
        if (EVT_CNT !== 16'd0) begin errors++; $display("FAIL tmo_evt_cnt_end: got %0d want 0", EVT_CNT); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_event();
        test_ack_first_cycle();
        test_round_robin();
`ifdef AER_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_fifo_full();
`endif
        test_ctrl_order();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aer_map_scheduler.md
# aer_map_scheduler

Sequencer in front of the AER local-receptive-field mapper. It merges events from up to `N_SRC` producers, arbitrating round-robin between them. Accepted events are buffered in order in a shared FIFO. Each event is then issued to the mapper's single AER input with a REQ/ACK handshake, one event in flight at a time. Status outputs report occupancy, completed-event count and, optionally, ACK-timeout errors.

## Interface
- `N_SRC`, 4: number of event producers (≥2)
- `AER_WIDTH`, 12: event word width; bits [AER_WIDTH-1:AER_WIDTH-2] are the event type
- `FIFO_DEPTH`, 8: shared FIFO entries (power of two)
- `DRAIN_CYC`, 1: minimum REQ-low cycles between events (≥1)
- `TIMEOUT_CYC`, 255: ACK watchdog limit, used only with the timeout macro
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `SRC_VALID`  in  N_SRC  per-source event valid
- `SRC_EVENT`  in  N_SRC×AER_WIDTH  per-source event word
- `SRC_IDX`  in  N_SRC×(AER_WIDTH-2)  per-source neuron index
- `SRC_READY`  out  N_SRC  per-source accept; one-hot or zero
- `MAP_AERIN_REQ`  out  1  request to mapper, registered
- `MAP_AERIN_EVENT`  out  AER_WIDTH  event to mapper, registered
- `MAP_AERIN_IDX`  out  AER_WIDTH-2  index to mapper, registered
- `MAP_AERIN_ACK`  in  1  mapper acknowledge
- `BUSY`  out  1  FIFO non-empty or FSM not IDLE
- `FIFO_LEVEL`  out  $clog2(FIFO_DEPTH)+1  current occupancy
- `EVT_CNT`  out  16  completed events, wraps at 0xFFFF→0
- `TIMEOUT_ERR`  out  1  sticky ACK-timeout flag

## Operation
- **Arbitration:**
  - Grant goes to the first asserted `SRC_VALID` searching from `rr_ptr+1` modulo `N_SRC`.
  - `SRC_READY[g]` = grant[g] & !fifo_full. A push occurs when valid & ready; `{EVENT,IDX}` is written to the FIFO.
  - `rr_ptr` updates to g only on a push.
- **Full FIFO:** `SRC_READY` is all-zero when the FIFO is full, even if a pop happens in the same cycle. Push and pop in the same cycle on a non-full, non-empty FIFO leave the level unchanged.
- **Event types:** all types, including broadcast/control types 01 and 10, pass through unchanged. Strict FIFO order is kept, so a control event never overtakes earlier neuron events.
- **FSM states:**
  - IDLE: if FIFO non-empty, pop, load `MAP_AERIN_EVENT/IDX`, set REQ=1, go to SEND.
  - SEND: REQ=1, data held stable. `MAP_AERIN_ACK` is ignored in the first SEND cycle. When ACK=1 is sampled from the second cycle onward: REQ=0, `EVT_CNT`+1, go to DRAIN.
  - DRAIN: REQ=0 for exactly `DRAIN_CYC` cycles, then go to IDLE.
- **Reset:** every output is 0, the FIFO is empty, `rr_ptr`=N_SRC-1 (so source 0 wins first), state is IDLE. A reset asserted mid-SEND drops REQ immediately (asynchronous) and discards the buffered events.

## Timing
- Push at edge t makes the FIFO non-empty in cycle t+1. REQ rises at edge t+2.
- Best-case ACK is at SEND cycle 2. REQ is then low after the following edge.
- Throughput with immediate ACK and `DRAIN_CYC`=1 is one event per 4 cycles.
- `FIFO_LEVEL` and `BUSY` are registered-consistent: they reflect the state after the last edge.
- `EVENT`/`IDX` change only on the IDLE→SEND transition.

## Configuration
- `AER_SCHED_TIMEOUT_EN` **defined:**
  - An 8..16-bit counter clears on entry to SEND and increments each SEND cycle.
  - When the counter reaches `TIMEOUT_CYC` with no ACK: REQ=0, go to DRAIN, set `TIMEOUT_ERR`=1 (sticky until reset). The event is dropped and `EVT_CNT` is not incremented.
- `AER_SCHED_TIMEOUT_EN` **undefined:**
  - SEND waits indefinitely and no counter is built.
  - `TIMEOUT_ERR` is tied to 0.

## Structure
- Package `aer_sched_pkg`:
  - FSM enum `sched_state_e` {IDLE, SEND, DRAIN}
  - Event-type constants: NEUR=2'b00, CTRL_A=2'b01, CTRL_B=2'b10, INVALID=2'b11
  - `EVT_CNT` width constant
- Sub-module `aer_sched_fifo`: synchronous FIFO with `DEPTH`/`WIDTH` parameters, full/empty/level outputs, asynchronous active-low reset. The arbiter and FSM stay in the top module.

## Test plan
- **Single event:** source 2 sends EVENT=0x0A5, IDX=0x25; ACK is returned 3 cycles after REQ rises. Expect `SRC_READY[2]` for 1 cycle, REQ high from t+2 for 3 cycles, EVENT/IDX matching, `EVT_CNT`=1.
- **Round-robin fairness:** all 4 sources hold VALID for 12 pushes. Expect grant order 0,1,2,3,0,1,…, each source accepted 3 times.
- **FIFO full:** ACK held 0 (timeout macro undefined) with `FIFO_DEPTH`=8. Expect 1 event in SEND plus 8 buffered, then `SRC_READY`=0 and `FIFO_LEVEL`=8. Releasing ACK drains all 9 in push order.
- **Control ordering:** push neuron events N1, N2, then type 01 event C, then N3. Expect mapper output order N1, N2, C, N3 with payloads unchanged.
- **Timeout:** macro defined, `TIMEOUT_CYC`=10, ACK never asserted. Expect REQ to drop after 10 SEND cycles, `TIMEOUT_ERR`=1, `EVT_CNT` unchanged, and the next event issued.
- **Reset mid-SEND:** assert `rst_n`=0 while REQ=1 and FIFO_LEVEL=3. Expect REQ=0 immediately, `FIFO_LEVEL`=0, and source 0 winning first after release.
